// File: rtl/fp_pkg.sv
// Shared single-precision field helpers, constants and divider FSM states.
package fp_pkg;

    localparam logic [31:0] FP_TWO        = 32'h4000_0000;
    localparam logic [31:0] FP_QNAN       = 32'h7FC0_0000;
    localparam logic [30:0] FP_INF_MAG    = 31'h7F80_0000;
    localparam logic [31:0] FP_SEED_MAGIC = 32'h7EF3_11C3;
    localparam logic [7:0]  FP_EXP_MAX    = 8'hFF;
    // Divisors this large give a seed that underflows, so the quotient is flushed.
    localparam logic [7:0]  FP_EXP_SAT    = 8'hFD;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        MUL_DX,
        SUB_2,
        MUL_XT,
        MUL_AQ,
        DONE
    } state_t;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] fp_man(input logic [31:0] x);
        return x[22:0];
    endfunction

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (fp_exp(x) == FP_EXP_MAX) && (fp_man(x) != 23'h0);
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] x);
        return (fp_exp(x) == FP_EXP_MAX) && (fp_man(x) == 23'h0);
    endfunction

    // Subnormals flush to zero, so a zero exponent alone means zero.
    function automatic logic fp_is_zero(input logic [31:0] x);
        return fp_exp(x) == 8'h00;
    endfunction

endpackage

// File: rtl/fp_addsub.sv
// Single-precision add/subtract (y = a +/- b), round-to-nearest-even, flush-to-zero.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module fp_addsub
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] y
);

    logic [31:0]        bx;
    logic [31:0]        big;
    logic [31:0]        sml;
    logic [7:0]         d;
    logic [26:0]        mb;
    logic [26:0]        mshift;
    logic               lost;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic               found;
    logic [26:0]        n;
    logic signed [9:0]  e;
    logic [24:0]        r;

    always_comb begin
        bx  = {fp_sign(b) ^ sub, b[30:0]};
        big = (a[30:0] >= b[30:0]) ? a : bx;
        sml = (a[30:0] >= b[30:0]) ? bx : a;
        d   = fp_exp(big) - fp_exp(sml);
        mb  = {1'b1, fp_man(sml), 3'b000};
        if (d >= 8'd27) begin
            mshift = 27'h0;
            lost   = 1'b1;
        end else begin
            mshift = mb >> d;
            lost   = |(mb & ~(27'h7FF_FFFF << d));
        end
        mshift[0] = mshift[0] | lost;

        if (fp_sign(big) == fp_sign(sml)) begin
            sum = {2'b01, fp_man(big), 3'b000} + {1'b0, mshift};
        end else begin
            sum = {2'b01, fp_man(big), 3'b000} - {1'b0, mshift};
        end

        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end

        e = $signed({2'b00, fp_exp(big)});
        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'sd1;
        end else begin
            n = sum[26:0] << lz;
            e = e - $signed({5'b00000, lz});
        end
        r = {1'b0, n[26:3]} + {24'h0, n[2] & (n[1] | n[0] | n[3])};
        if (r[24]) begin
            e = e + 10'sd1;
        end
        y = {fp_sign(big), e[7:0], r[24] ? r[23:1] : r[22:0]};

        if (fp_is_nan(big) || fp_is_nan(sml) ||
            (fp_is_inf(big) && fp_is_inf(sml) && (fp_sign(big) != fp_sign(sml)))) begin
            y = FP_QNAN;
        end else if (fp_is_inf(big)) begin
            y = {fp_sign(big), FP_INF_MAG};
        end else if (fp_is_zero(sml)) begin
            y = fp_is_zero(big) ? 32'h0 : big;
        end else if (sum == 28'h0 || e <= 10'sd0) begin
            y = 32'h0;
        end else if (e >= 10'sd255) begin
            y = {fp_sign(big), FP_INF_MAG};
        end
    end

endmodule

// File: rtl/fp_mul.sv
// Single-precision multiplier, round-to-nearest-even, flush-to-zero.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module fp_mul
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic               sign;
    logic [47:0]        prod;
    logic signed [9:0]  e;
    logic [22:0]        m;
    logic               g;
    logic               st;
    logic [24:0]        r;

    always_comb begin
        sign = fp_sign(a) ^ fp_sign(b);
        prod = {24'h0, 1'b1, fp_man(a)} * {24'h0, 1'b1, fp_man(b)};
        e    = $signed({2'b00, fp_exp(a)}) + $signed({2'b00, fp_exp(b)}) - 10'sd127;
        if (prod[47]) begin
            m  = prod[46:24];
            g  = prod[23];
            st = |prod[22:0];
            e  = e + 10'sd1;
        end else begin
            m  = prod[45:23];
            g  = prod[22];
            st = |prod[21:0];
        end
        r = {2'b01, m} + {24'h0, g & (st | m[0])};
        if (r[24]) begin
            e = e + 10'sd1;
        end
        y = {sign, e[7:0], r[24] ? r[23:1] : r[22:0]};

        if (fp_is_nan(a) || fp_is_nan(b)) begin
            y = FP_QNAN;
        end else if (fp_is_zero(a) || fp_is_zero(b)) begin
            y = {sign, 31'h0};
        end else if (fp_is_inf(a) || fp_is_inf(b) || (e >= 10'sd255)) begin
            y = {sign, FP_INF_MAG};
        end else if (e <= 10'sd0) begin
            y = {sign, 31'h0};
        end
    end

endmodule

// File: rtl/fp_special_case.sv
// Classifies divide operands and supplies the result override and flags.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module fp_special_case
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ovr_en,
    output logic [31:0] ovr_val,
    output logic        invalid,
    output logic        div_by_zero
);

    logic s;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    always_comb begin
        s           = fp_sign(a) ^ fp_sign(b);
        a_nan       = fp_is_nan(a);
        b_nan       = fp_is_nan(b);
        a_inf       = fp_is_inf(a);
        b_inf       = fp_is_inf(b);
        a_zero      = fp_is_zero(a);
        b_zero      = fp_is_zero(b);
        ovr_en      = 1'b1;
        ovr_val     = 32'h0;
        invalid     = 1'b0;
        div_by_zero = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            ovr_val = FP_QNAN;
            invalid = 1'b1;
        end else if (a_inf) begin
            ovr_val = {s, FP_INF_MAG};
        end else if (b_zero) begin
            ovr_val     = {s, FP_INF_MAG};
            div_by_zero = 1'b1;
        end else if (b_inf || a_zero || (fp_exp(b) >= FP_EXP_SAT)) begin
            ovr_val = {s, 31'h0};
        end else begin
            ovr_en = 1'b0;
        end
    end

endmodule

// File: rtl/fp_divide_nr.sv
// Newton-Raphson single-precision divider sharing one multiplier and one subtractor.
// Latency: done 3*ITER+2 edges after the accepting edge, fixed for all operands.
// Backpressure: start is ignored while busy; no queueing.
module fp_divide_nr
    import fp_pkg::*;
#(
    parameter int          ITER       = 3,
    parameter logic [31:0] SEED_MAGIC = FP_SEED_MAGIC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic        div_by_zero,
    output logic        invalid
);

    state_t      state_q, state_d;
    logic [31:0] a_q, b_q, x_q, t_q;
    logic [2:0]  cnt_q;
    logic [31:0] mul_a, mul_b, mul_y, sub_y;
    logic [30:0] seed_mag;
    logic        ovr_en, sc_invalid, sc_dbz;
    logic [31:0] ovr_val;

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    // Low 31 bits of the 32-bit subtraction; the seed sign is forced positive.
    assign seed_mag = SEED_MAGIC[30:0] - b_q[30:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEED;
            SEED:    state_d = MUL_DX;
            MUL_DX:  state_d = SUB_2;
            SUB_2:   state_d = MUL_XT;
            MUL_XT:  state_d = (cnt_q == 3'(ITER - 1)) ? MUL_AQ : MUL_DX;
            MUL_AQ:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mul_a = x_q;
        mul_b = t_q;
        case (state_q)
            MUL_DX:  begin mul_a = {1'b0, b_q[30:0]}; mul_b = x_q; end
            MUL_AQ:  begin mul_a = {1'b0, a_q[30:0]}; mul_b = x_q; end
            default: begin mul_a = x_q;               mul_b = t_q; end
        endcase
    end

    fp_mul u_mul (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    fp_addsub u_sub (
        .a   (FP_TWO),
        .b   (t_q),
        .sub (1'b1),
        .y   (sub_y)
    );

    fp_special_case u_special (
        .a           (a_q),
        .b           (b_q),
        .ovr_en      (ovr_en),
        .ovr_val     (ovr_val),
        .invalid     (sc_invalid),
        .div_by_zero (sc_dbz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            x_q         <= 32'h0;
            t_q         <= 32'h0;
            cnt_q       <= 3'd0;
            quotient    <= 32'h0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q         <= dividend;
                        b_q         <= divisor;
                        div_by_zero <= 1'b0;
                        invalid     <= 1'b0;
                    end
                end
                SEED: begin
                    x_q   <= {1'b0, seed_mag};
                    cnt_q <= 3'd0;
                end
                MUL_DX: t_q <= mul_y;
                SUB_2:  t_q <= sub_y;
                MUL_XT: begin
                    x_q   <= mul_y;
                    cnt_q <= cnt_q + 3'd1;
                end
                MUL_AQ: begin
                    quotient    <= ovr_en ? ovr_val : {a_q[31] ^ b_q[31], mul_y[30:0]};
                    invalid     <= sc_invalid;
                    div_by_zero <= sc_dbz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divide_nr.sv
// Directed-vector bench for fp_divide_nr: results, flags, latency and handshake corners.
module tb_fp_divide_nr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic        div_by_zero;
    logic        invalid;

    int total = 0;
    int bad   = 0;

    localparam int LAT = 11;

    fp_divide_nr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        int          tol;
        logic        inv;
        logic        dbz;
        string       name;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want,
                       input int tol);
        int diff;
        total++;
        diff = int'(got[30:0]) - int'(want[30:0]);
        if (diff < 0) diff = -diff;
        if ((^got === 1'bx) || (got[31] !== want[31]) || (diff > tol)) begin
            bad++;
            $display("FAIL %s: got %h want %h (tol %0d)", name, got, want, tol);
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int extra_at,
                           output logic [31:0] q, output logic inv, output logic dbz,
                           output int lat, output logic busy_ok);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = -1;
        q       = 32'hDEAD_BEEF;
        inv     = 1'bx;
        dbz     = 1'bx;
        busy_ok = busy;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (extra_at > 0 && n == extra_at + 1) start = 1'b0;
            if (done) begin
                lat = n;
                q   = quotient;
                inv = invalid;
                dbz = div_by_zero;
                if (!busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (extra_at > 0 && n == extra_at) begin
                start    = 1'b1;
                dividend = 32'h3F80_0000;
                divisor  = 32'h0000_0000;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] q;
        logic        inv, dbz, bok;
        int          lat;
        int          ndone;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'h0;
        divisor  = 32'h0;
        #1;
        chk("reset busy", {31'h0, busy}, 32'h0, 0);
        chk("reset done", {31'h0, done}, 32'h0, 0);
        chk("reset quotient", quotient, 32'h0, 0);
        chk("reset invalid", {31'h0, invalid}, 32'h0, 0);
        chk("reset dbz", {31'h0, div_by_zero}, 32'h0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 4, 1'b0, 1'b0, "6/3"};
        vecs[1]  = '{32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 4, 1'b0, 1'b0, "-7.5/2.5"};
        vecs[2]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 0, 1'b0, 1'b1, "1/0"};
        vecs[3]  = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 0, 1'b0, 1'b1, "-1/0"};
        vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 0, 1'b1, 1'b0, "0/0"};
        vecs[5]  = '{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 0, 1'b1, 1'b0, "inf/inf"};
        vecs[6]  = '{32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 0, 1'b0, 1'b0, "0/5"};
        vecs[7]  = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 0, 1'b1, 1'b0, "nan/1"};
        vecs[8]  = '{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 0, 1'b0, 1'b0, "inf/2"};
        vecs[9]  = '{32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 0, 1'b0, 1'b0, "1/inf"};
        vecs[10] = '{32'hC000_0000, 32'h7F00_0000, 32'h8000_0000, 0, 1'b0, 1'b0, "-2/huge"};
        vecs[11] = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 4, 1'b0, 1'b0, "1/2"};
        vecs[12] = '{32'h42C8_0000, 32'h4120_0000, 32'h4120_0000, 4, 1'b0, 1'b0, "100/10"};
        vecs[13] = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4, 1'b0, 1'b0, "1/3"};
        vecs[14] = '{32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 0, 1'b0, 1'b0, "subn/1"};

        for (int i = 0; i < 15; i++) begin
            run_div(vecs[i].a, vecs[i].b, 0, q, inv, dbz, lat, bok);
            chk({vecs[i].name, " quotient"}, q, vecs[i].q, vecs[i].tol);
            chk({vecs[i].name, " invalid"}, {31'h0, inv}, {31'h0, vecs[i].inv}, 0);
            chk({vecs[i].name, " dbz"}, {31'h0, dbz}, {31'h0, vecs[i].dbz}, 0);
            chk({vecs[i].name, " latency"}, 32'(lat), 32'(LAT), 0);
            chk({vecs[i].name, " busy"}, {31'h0, bok}, 32'h1, 0);
            @(posedge clk);
            #1;
            chk({vecs[i].name, " done pulse"}, {31'h0, done}, 32'h0, 0);
            chk({vecs[i].name, " busy fall"}, {31'h0, busy}, 32'h0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("quotient held", quotient, vecs[14].q, 0);

        // A second start inside a running divide must be dropped, not queued.
        run_div(32'h40C0_0000, 32'h4040_0000, 4, q, inv, dbz, lat, bok);
        chk("ignored start quotient", q, 32'h4000_0000, 4);
        chk("ignored start dbz", {31'h0, dbz}, 32'h0, 0);
        chk("ignored start latency", 32'(lat), 32'(LAT), 0);
        chk("ignored start busy", {31'h0, bok}, 32'h1, 0);
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("ignored start extra done", 32'(ndone), 32'h0, 0);

        // Reset in the middle of a divide clears outputs without waiting for an edge.
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'h3F80_0000;
        divisor  = 32'h4040_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy", {31'h0, busy}, 32'h0, 0);
        chk("abort done", {31'h0, done}, 32'h0, 0);
        chk("abort quotient", quotient, 32'h0, 0);
        chk("abort invalid", {31'h0, invalid}, 32'h0, 0);
        chk("abort dbz", {31'h0, div_by_zero}, 32'h0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("abort no done", 32'(ndone), 32'h0, 0);
        run_div(32'hC0F0_0000, 32'h4020_0000, 0, q, inv, dbz, lat, bok);
        chk("after reset quotient", q, 32'hC040_0000, 4);
        chk("after reset latency", 32'(lat), 32'(LAT), 0);
        chk("after reset invalid", {31'h0, inv}, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
